clp_instr_dispatch: RTL
=======================

# clp_instr_dispatch

Parametrised instruction store and dispatcher between the host/ARM load path and a bank of CLP compute channels. The host writes a program into an on-chip instruction RAM and pulses `acc_enable`. The block then fetches instructions in order and routes each one to the CLP channel named in its top bits, using a valid/ready handshake. It reports busy/done and waits for every channel to go idle before declaring the program complete.

## Interface
- `INSTR_W`, 64, instruction width in bits.
- `DEPTH`, 1024, number of instruction RAM entries; must be a power of two.
- `ADDR_W`, $clog2(DEPTH), instruction address width.
- `NUM_CLP`, 2, number of CLP channels; range 1..8.
- `CH_W`, max(1,$clog2(NUM_CLP)), width of the channel-select field.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_instr_enable`  in  1  host write strobe into the instruction RAM.
- `load_instr_addr`  in  ADDR_W  host write address.
- `load_instr_data`  in  INSTR_W  host write data.
- `instr_count`  in  ADDR_W+1  number of instructions to run; sampled on start.
- `acc_enable`  in  1  start request; level is sampled and acted on only in IDLE.
- `instr_port`  out  INSTR_W  instruction being offered, shared by all channels.
- `instr_valid`  out  NUM_CLP  one-hot offer to the target channel.
- `instr_ready`  in  NUM_CLP  per-channel accept.
- `CLP_state`  in  NUM_CLP  per-channel status: 0 = idle, 1 = busy.
- `busy`  out  1  program in progress.
- `done`  out  1  one-cycle pulse when the program completes.
- `pc`  out  ADDR_W+1  index of the next instruction to issue.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, and `pc` is 0.
- The RAM is written when `load_instr_enable` is high and the FSM is in IDLE. Writes in any other state are dropped.
- Channel of an instruction = `instr[INSTR_W-1 -: CH_W]`. If this value is ≥ NUM_CLP, the instruction goes to channel `value % NUM_CLP`.
- FSM states: IDLE, FETCH, ISSUE, DRAIN, FIN.
- IDLE:
  - On `acc_enable`, latch `min(instr_count, DEPTH)` as `cnt`, clear `pc`, and set `busy`.
  - If `cnt == 0`, go to DRAIN; otherwise go to FETCH.
- FETCH: drive RAM read address = `pc`, then go to ISSUE.
- ISSUE:
  - Drive the RAM output onto `instr_port`.
  - Hold `instr_valid[ch]` high and `instr_port` stable until `instr_ready[ch]` is high.
  - On the handshake, increment `pc`. If `pc + 1 == cnt`, go to DRAIN; otherwise go to FETCH.
- DRAIN: wait until `CLP_state == 0` and `instr_valid == 0`, then go to FIN.
- FIN: pulse `done` for one cycle, clear `busy`, and return to IDLE.
- `acc_enable` is ignored while `busy` is high. There is no restart or abort input.
- Reset mid-program: on the asynchronous assert, the block returns immediately to IDLE with all outputs at 0. RAM contents are not cleared.

## Timing
- RAM read latency: 1 cycle (synchronous read).
- `acc_enable` high at cycle t → FETCH at t+1 → `instr_valid` high at t+2.
- Throughput: at most 1 instruction per 2 cycles (FETCH + ISSUE) when ready is always high.
- Zero-latency ready: a handshake completes in the same cycle that `instr_ready` is seen high while valid is high.
- Completion latency: `done` rises 2 cycles after the cycle in which `CLP_state` is first seen all-zero in DRAIN (1 cycle to move to FIN, pulse in FIN). `busy` falls in the same cycle that `done` rises.
- `cnt == 0`: `acc_enable` at t → `done` at t+3, provided `CLP_state == 0` (IDLE → DRAIN → FIN).
- A host write and `acc_enable` in the same IDLE cycle: the write is committed and is visible to the program.

## Structure
- Shared package `tproc_dispatch_pkg` holds:
  - the state enum (IDLE, FETCH, ISSUE, DRAIN, FIN);
  - the `ch_of()` channel-extract function;
  - constants for the default widths.
- One sub-module, `instr_ram`: simple dual-port RAM (1 write port, 1 synchronous read port), parametrised by INSTR_W and DEPTH.
- The FSM, counters and the one-hot valid decode live in `clp_instr_dispatch`.

## Test plan
- Load 4 instructions with channel bits 0,1,0,1 and `instr_count = 4`, hold ready = 1 → `instr_valid` sequence 01,10,01,10 on alternate cycles; `instr_port` matches the RAM contents; `pc` ends at 4; `done` pulses once.
- Hold `instr_ready[1] = 0` for 5 cycles during an offer → `instr_valid[1]` and `instr_port` stay stable for 5 cycles; `pc` does not advance; the handshake completes on the first ready cycle.
- `instr_count = 0` with `acc_enable` → no `instr_valid` ever; `done` at t+3; `busy` high for 2 cycles.
- Hold `CLP_state[0] = 1` for 10 cycles after the last issue → `done` is delayed until 2 cycles after it drops; a second `acc_enable` while busy is ignored.
- Host write during busy to address 0 → the RAM is unchanged (a re-run issues the original word); `instr_count = DEPTH + 1` saturates to DEPTH issues.
- Assert `rst` low mid-ISSUE → `instr_valid`, `busy`, `done` and `pc` are 0 immediately; after release, a new `acc_enable` reruns the program from `pc = 0`.

Source files
------------

// File: rtl/tproc_dispatch_pkg.sv
// Shared types and helpers for the CLP instruction dispatcher.
package tproc_dispatch_pkg;

  localparam int unsigned DefInstrW = 64;
  localparam int unsigned DefDepth  = 1024;
  localparam int unsigned DefNumClp = 2;
  localparam int unsigned MaxNumClp = 8;
  localparam int unsigned ChSelMaxW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StDrain,
    StFin
  } disp_state_e;

  // Out-of-range channel fields wrap onto the populated channels.
  function automatic logic [ChSelMaxW-1:0] ch_of(input logic [ChSelMaxW-1:0] field,
                                                 input int unsigned           num_clp);
    logic [31:0] v;
    v = 32'(field) % num_clp;
    return v[ChSelMaxW-1:0];
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port instruction store: one write port, one synchronous read port.
module instr_ram #(
  parameter int unsigned INSTR_W = 64,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/clp_instr_dispatch.sv
// Fetches a host-loaded program in order and routes each instruction to the CLP
// channel named in its top bits over a valid/ready handshake.
module clp_instr_dispatch
  import tproc_dispatch_pkg::*;
#(
  parameter int unsigned INSTR_W = DefInstrW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned NUM_CLP = DefNumClp,
  parameter int unsigned CH_W    = (NUM_CLP > 1) ? $clog2(NUM_CLP) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_instr_enable,
  input  logic [ADDR_W-1:0]  load_instr_addr,
  input  logic [INSTR_W-1:0] load_instr_data,
  input  logic [ADDR_W:0]    instr_count,
  input  logic               acc_enable,
  output logic [INSTR_W-1:0] instr_port,
  output logic [NUM_CLP-1:0] instr_valid,
  input  logic [NUM_CLP-1:0] instr_ready,
  input  logic [NUM_CLP-1:0] CLP_state,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    pc
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  disp_state_e          state_q;
  logic [ADDR_W:0]      cnt_q;
  logic [ADDR_W:0]      pc_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 ram_we;
  logic                 ram_re;
  logic [INSTR_W-1:0]   ram_rdata;
  logic [ADDR_W:0]      cnt_sat;
  logic [ADDR_W:0]      pc_inc;
  logic [CH_W-1:0]      ch_field;
  logic [ChSelMaxW-1:0] ch_sel;
  logic                 handshake;

  // Host writes land only while idle so a running program is never disturbed.
  assign ram_we = load_instr_enable && (state_q == StIdle);
  assign ram_re = (state_q == StFetch);

  instr_ram #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_instr_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_instr_addr),
    .wdata (load_instr_data),
    .re    (ram_re),
    .raddr (pc_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign cnt_sat  = (instr_count > DepthCnt) ? DepthCnt : instr_count;
  assign pc_inc   = pc_q + 1'b1;
  assign ch_field = ram_rdata[INSTR_W-1 -: CH_W];
  assign ch_sel   = ch_of(ChSelMaxW'(ch_field), NUM_CLP);

  always_comb begin
    instr_valid = '0;
    if (state_q == StIssue) begin
      for (int i = 0; i < NUM_CLP; i++) begin
        instr_valid[i] = (ch_sel == ChSelMaxW'(i));
      end
    end
  end

  // The RAM output register holds its word through ISSUE, keeping the port stable.
  assign instr_port = (state_q == StIssue) ? ram_rdata : '0;
  assign handshake  = (state_q == StIssue) && ((instr_valid & instr_ready) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (acc_enable) begin
            cnt_q   <= cnt_sat;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= (cnt_sat == '0) ? StDrain : StFetch;
          end
        end
        StFetch: begin
          state_q <= StIssue;
        end
        StIssue: begin
          if (handshake) begin
            pc_q    <= pc_inc;
            state_q <= (pc_inc == cnt_q) ? StDrain : StFetch;
          end
        end
        StDrain: begin
          if ((CLP_state == '0) && (instr_valid == '0)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pc   = pc_q;

endmodule
